// File: rtl/matrix_fifo_rd_ctrl_if.sv
// FIFO read port plus tagged pixel stream between the matrix FIFO, the read
// controller and the convolution window logic.
interface matrix_fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rd_en;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_sol;
    logic                  m_eol;
    logic                  m_sof;
    logic                  m_eof;

    modport master (
        output rd_en,
        input  rd_vld,
        input  rd_data,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_sol,
        output m_eol,
        output m_sof,
        output m_eof
    );

    modport slave (
        input  rd_en,
        output rd_vld,
        output rd_data,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_sol,
        input  m_eol,
        input  m_sof,
        input  m_eof
    );
endinterface

// File: rtl/matrix_fifo_rd_ctrl.sv
// Drains the show-ahead matrix FIFO into a registered pixel stream tagged with line/frame flags.
// Optional starvation counter port stall_cnt enabled by MATRIX_RD_STALL_CNT_EN.
//
// state | meaning
// IDLE  | waiting for start (ignored in the frame_done cycle)
// RUN   | popping pixels of the current frame
// DRAIN | last pixel popped, waiting for it to be accepted downstream
module matrix_fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 416,
    parameter int IMG_H      = 416,
    parameter int CNT_WIDTH  = 10
) (
    input  logic rd_clk,
    input  logic rd_rst,
    input  logic start,
    output logic busy,
    output logic frame_done,
`ifdef MATRIX_RD_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    matrix_fifo_rd_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_W - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_H - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  col_q, col_d;
    logic [CNT_WIDTH-1:0]  row_q, row_d;
    logic                  frame_done_q;
    logic                  m_valid_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_sol_q, m_eol_q, m_sof_q, m_eof_q;

    logic out_free, pop, accept, last_pix, start_ok;

    assign out_free = !m_valid_q || bus.m_ready;
    assign accept   = m_valid_q && bus.m_ready;
    assign pop      = (state_q == S_RUN) && bus.rd_vld && out_free && !rd_rst;
    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    // a start coinciding with the frame_done pulse belongs to the finished frame
    assign start_ok = start && !frame_done_q;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= (state_q == S_DRAIN) && accept;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (pop) begin
                    if (last_pix) begin
                        state_d = S_DRAIN;
                        col_d   = '0;
                        row_d   = '0;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + CNT_WIDTH'(1);
                    end else begin
                        col_d = col_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (accept) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        bus.rd_en = pop;
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sol_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eof_q   <= 1'b0;
        end else if (pop) begin
            m_valid_q <= 1'b1;
            m_data_q  <= bus.rd_data;
            m_sol_q   <= (col_q == '0);
            m_eol_q   <= (col_q == COL_LAST);
            m_sof_q   <= (col_q == '0) && (row_q == '0);
            m_eof_q   <= last_pix;
        end else if (accept) begin
            m_valid_q <= 1'b0;
        end
    end

    assign frame_done  = frame_done_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_sol   = m_sol_q;
    assign bus.m_eol   = m_eol_q;
    assign bus.m_sof   = m_sof_q;
    assign bus.m_eof   = m_eof_q;

`ifdef MATRIX_RD_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && start_ok) begin
            stall_q <= '0;
        end else if ((state_q == S_RUN) && !bus.rd_vld && out_free && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_matrix_fifo_rd_ctrl.sv
// Scoreboard bench for matrix_fifo_rd_ctrl on a 4x2 frame with a queue-modelled show-ahead FIFO.
module tb_matrix_fifo_rd_ctrl;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 2;

    logic clk = 1'b0;
    logic rd_rst, start, busy, frame_done;
`ifdef MATRIX_RD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    matrix_fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) bus();

    matrix_fifo_rd_ctrl #(
        .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .CNT_WIDTH(10)
    ) dut (
        .rd_clk     (clk),
        .rd_rst     (rd_rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
`ifdef MATRIX_RD_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .bus        (bus)
    );

    int total = 0, bad = 0;
    int cyc = 0, n_pops = 0, n_done = 0, n_acc = 0;
    int first_pop = -1, last_pop = -1, acc_eof_cyc = -10;
    logic [7:0]  fifo[$];
    logic [7:0]  src[$];
    logic [11:0] exp_q[$];
    bit rdy_toggle = 0, feed_en = 0, check_stall = 0;
    int rdy_idx = 0, feed_ph = 0, exp_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // expected beat: {data, sof, sol, eol, eof} for pixel index i of a 4x2 frame
    function automatic logic [11:0] beat(input logic [7:0] first, input int i);
        logic [7:0] d;
        d = first + 8'(i);
        return {d, (i == 0), (i % W == 0), (i % W == W - 1), (i == W * H - 1)};
    endfunction

    task automatic cycle();
        logic pop_now;
        @(negedge clk);
        cyc++;
        if (feed_en) begin
            if (feed_ph == 0 && src.size() > 0) fifo.push_back(src.pop_front());
            feed_ph = (feed_ph == 2) ? 0 : feed_ph + 1;
        end
        bus.m_ready = rdy_toggle ? (rdy_idx == 0 || rdy_idx == 3) : 1'b1;
        if (rdy_toggle) rdy_idx = (rdy_idx + 1) % 4;
        bus.rd_vld  = (fifo.size() > 0);
        bus.rd_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
        #1;
        pop_now = bus.rd_en;
        if (pop_now) begin
            check("rd_en_without_vld", 32'(bus.rd_vld), 32'd1);
            n_pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge clk);
        #1;
        if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 300 && n_done < target; k++) cycle();
        check("frame_done_timeout", 32'(n_done), 32'(target));
    endtask

    task automatic run_frame(input logic [7:0] first, input int target);
        for (int i = 0; i < W * H; i++) exp_q.push_back(beat(first, i));
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(target);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fifo.push_back(first + 8'(i));
    endtask

    // monitor: pops the scoreboard whenever a beat is accepted downstream
    initial begin
        logic        hold_prev;
        logic [11:0] prev_beat;
        logic [11:0] e;
        hold_prev = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rd_rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev)
                    check("hold_while_stalled",
                          {19'd0, bus.m_valid, bus.m_data, bus.m_sof, bus.m_sol, bus.m_eol, bus.m_eof},
                          {19'd0, 1'b1, prev_beat});
                if (bus.m_valid && bus.m_ready) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got data %0h expected no beat", bus.m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {20'd0, bus.m_data, bus.m_sof, bus.m_sol, bus.m_eol, bus.m_eof},
                              {20'd0, e});
                    end
                    if (bus.m_eof) acc_eof_cyc = cyc;
                end
                hold_prev = bus.m_valid && !bus.m_ready;
                prev_beat = {bus.m_data, bus.m_sof, bus.m_sol, bus.m_eol, bus.m_eof};
                if (frame_done) begin
                    n_done++;
                    check("frame_done_latency", 32'(cyc), 32'(acc_eof_cyc + 1));
                    check("busy_at_frame_done", 32'(busy), 32'd0);
`ifdef MATRIX_RD_STALL_CNT_EN
                    if (check_stall) check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        rd_rst      = 1'b1;
        start       = 1'b0;
        bus.m_ready = 1'b1;
        bus.rd_vld  = 1'b0;
        bus.rd_data = '0;
        repeat (3) cycle();
        rd_rst = 1'b0;
        check("reset_outputs",
              {17'd0, busy, frame_done, bus.m_valid, bus.m_data, bus.m_sol, bus.m_eol,
               bus.m_sof, bus.m_eof, bus.rd_en}, 32'd0);

        // 1: preloaded frame, always ready
        load(8'h10, 8);
        n_pops = 0; first_pop = -1;
        run_frame(8'h10, 1);
        check("s1_pops", 32'(n_pops), 32'd8);
        check("s1_consecutive", 32'(last_pop - first_pop), 32'd7);

        // 2: ready toggling 1,0,0,1
        load(8'h10, 8);
        n_pops = 0; rdy_toggle = 1; rdy_idx = 0;
        run_frame(8'h10, 2);
        rdy_toggle = 0;
        check("s2_pops", 32'(n_pops), 32'd8);

        // 3: FIFO trickle-fed one byte every 3 cycles
        n_pops = 0;
        for (int i = 0; i < 8; i++) src.push_back(8'h10 + 8'(i));
        feed_en = 1; feed_ph = 2; check_stall = 1; exp_stall = 14;
        run_frame(8'h10, 3);
        feed_en = 0; check_stall = 0;
        check("s3_pops", 32'(n_pops), 32'd8);

        // 4: 12 bytes, only one frame drained, then second frame from byte 8
        load(8'h20, 12);
        n_pops = 0;
        run_frame(8'h20, 4);
        repeat (5) cycle();
        check("s4_pops", 32'(n_pops), 32'd8);
        check("s4_fifo_left", 32'(fifo.size()), 32'd4);
        load(8'h2C, 4);
        n_pops = 0;
        run_frame(8'h28, 5);
        check("s4b_pops", 32'(n_pops), 32'd8);

        // 5: reset after third beat, then restart on the next FIFO byte
        load(8'h30, 8);
        for (int i = 0; i < 3; i++) exp_q.push_back(beat(8'h30, i));
        n_acc = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 50 && n_acc < 3; k++) cycle();
        check("s5_three_beats", 32'(n_acc), 32'd3);
        rd_rst = 1'b1;
        cycle();
        rd_rst = 1'b0;
        check("s5_after_reset", {29'd0, busy, bus.m_valid, bus.rd_en}, 32'd0);
        check("s5_fifo_left", 32'(fifo.size()), 32'd4);
        check("s5_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        load(8'h38, 4);
        run_frame(8'h34, 6);

        // 6: starts in RUN, DRAIN and the frame_done cycle are dropped
        load(8'h40, 12);
        n_pops = 0;
        d0 = n_done;
        for (int i = 0; i < W * H; i++) exp_q.push_back(beat(8'h40, i));
        for (int i = 0; i < 30; i++) begin
            start = (i == 0 || i == 3 || i == 9 || i == 10);
            cycle();
        end
        start = 1'b0;
        check("s6_one_frame_done", 32'(n_done - d0), 32'd1);
        check("s6_pops", 32'(n_pops), 32'd8);
        check("s6_fifo_left", 32'(fifo.size()), 32'd4);
        check("s6_idle", 32'(busy), 32'd0);
        check("s6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
